uart_tx_arbiter: RTL

//  Round-robin arbiter sharing one UART_tx between NREQ byte requesters.

---
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte requesters, the round-robin arbiter and UART_tx.
// slave = arbiter side, master = client/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic [GW-1:0]     grant_id;
  logic              arb_busy;
  logic              tmo_err;

  modport slave (
    input  req, req_data, tx_busy,
    output ack, tx_start, tx_data, grant_id, arb_busy, tmo_err
  );

  modport master (
    output req, req_data, tx_busy,
    input  ack, tx_start, tx_data, grant_id, arb_busy, tmo_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_tx among NREQ byte requesters, with start-timeout watchdog.
// Optional UART_ARB_BURST_EN: a granted requester may send up to 4 back-to-back bytes.
//
// state     | meaning
// S_IDLE    | no transaction; arbitrate among pending requests
// S_LAUNCH  | tx_start and ack high for one cycle, watchdog armed
// S_WAIT_HI | waiting for tx_busy to rise, watchdog counting down
// S_WAIT_LO | frame in progress, waiting for tx_busy to fall
// S_BURST   | (burst build only) reload next byte of the same requester
module uart_tx_arbiter #(
  parameter int NREQ       = 4,
  parameter int TMO_CYCLES = 16
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3
`ifdef UART_ARB_BURST_EN
    , S_BURST = 3'd4
`endif
  } state_t;

  state_t          state, state_nx;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   grant_id_r;
  logic [7:0]      tx_data_r;
  logic [NREQ-1:0] ack_r;
  logic            tx_start_r;
  logic            tmo_err_r;
  logic [TW-1:0]   tmo_cnt;

  logic [GW-1:0]   winner;
  logic            found;
  logic [GW-1:0]   launch_id;
  logic            grab;
  logic            launch;
  logic            tmo_hit;
  logic            tmo_dec;
  logic            release_g;
`ifdef UART_ARB_BURST_EN
  logic [1:0]      burst_cnt;
  logic            burst_go;
`endif

  function automatic logic [GW-1:0] next_id(input logic [GW-1:0] g);
    if (int'(g) == NREQ - 1) return '0;
    return g + 1'b1;
  endfunction

  // Search starts at rr_ptr and wraps by explicit compare so odd NREQ works.
  always_comb begin
    int idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = GW'(idx);
      end
    end
  end

  always_comb begin
    state_nx  = state;
    grab      = 1'b0;
    tmo_hit   = 1'b0;
    tmo_dec   = 1'b0;
    release_g = 1'b0;
`ifdef UART_ARB_BURST_EN
    burst_go  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (found) begin
          grab     = 1'b1;
          state_nx = S_LAUNCH;
        end
      end
      S_LAUNCH: state_nx = S_WAIT_HI;
      S_WAIT_HI: begin
        if (bus.tx_busy) begin
          state_nx = S_WAIT_LO;
        end else if (tmo_cnt == '0) begin
          tmo_hit   = 1'b1;
          release_g = 1'b1;
          state_nx  = S_IDLE;
        end else begin
          tmo_dec = 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!bus.tx_busy) begin
`ifdef UART_ARB_BURST_EN
          if (bus.req[grant_id_r] && burst_cnt < 2'd3) begin
            burst_go = 1'b1;
            state_nx = S_BURST;
          end else begin
            release_g = 1'b1;
            state_nx  = S_IDLE;
          end
`else
          release_g = 1'b1;
          state_nx  = S_IDLE;
`endif
        end
      end
`ifdef UART_ARB_BURST_EN
      S_BURST: state_nx = S_LAUNCH;
`endif
      default: state_nx = S_IDLE;
    endcase
    launch    = (state_nx == S_LAUNCH);
    launch_id = grab ? winner : grant_id_r;
  end

  // tx_start/ack are registered on the edge that enters S_LAUNCH, so they coincide with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      grant_id_r <= '0;
      tx_data_r  <= 8'h00;
      ack_r      <= '0;
      tx_start_r <= 1'b0;
      tmo_err_r  <= 1'b0;
      tmo_cnt    <= '0;
`ifdef UART_ARB_BURST_EN
      burst_cnt  <= '0;
`endif
    end else begin
      state      <= state_nx;
      tx_start_r <= launch;
      ack_r      <= launch ? (NREQ'(1) << launch_id) : '0;
      tmo_err_r  <= tmo_hit;
      if (grab) begin
        grant_id_r <= winner;
        tx_data_r  <= bus.req_data[8*int'(winner) +: 8];
      end
      if (state == S_LAUNCH) tmo_cnt <= TW'(TMO_CYCLES - 1);
      else if (tmo_dec)      tmo_cnt <= tmo_cnt - 1'b1;
      if (release_g) rr_ptr <= next_id(grant_id_r);
`ifdef UART_ARB_BURST_EN
      if (grab)          burst_cnt <= '0;
      else if (burst_go) burst_cnt <= burst_cnt + 1'b1;
      if (state == S_BURST) tx_data_r <= bus.req_data[8*int'(grant_id_r) +: 8];
`endif
    end
  end

  assign bus.ack      = ack_r;
  assign bus.tx_start = tx_start_r;
  assign bus.tx_data  = tx_data_r;
  assign bus.grant_id = grant_id_r;
  assign bus.tmo_err  = tmo_err_r;
  assign bus.arb_busy = (state != S_IDLE);
endmodule
